store_lane_align: RTL and testbench
===================================

Name: store_lane_align

Overview:
- Store-path counterpart of the load-side sign/zero extension.
- Takes a 32-bit register value, a store size (byte/half/word) and a byte address from the datapath.
- Narrows and aligns the value onto the 4 byte lanes of a word-addressed data memory, generating byte enables.
- Drives the memory through a valid/ready write handshake, splitting word-crossing stores into two beats when enabled; sits between the EX/MEM control of the multicycle CPU and data memory.

Parameters:
- ADDR_W, 32, byte-address width; data width is fixed at 32 (4 lanes).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  store request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_addr  in  ADDR_W  byte address of store.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_data  in  32  register value; low bytes are stored.
- mem_valid  out  1  write beat valid.
- mem_ready  in  1  memory accepts beat.
- mem_addr  out  ADDR_W  word-aligned address (low 2 bits always 0).
- mem_wdata  out  32  lane-aligned write data; disabled lanes are 0.
- mem_be  out  4  byte enables; bit i = lane i = bits [8i+7:8i].
- done  out  1  one-cycle pulse: store completed.
- misalign_err  out  1  one-cycle pulse: request rejected, no memory write.

Behaviour:
- Clocking and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, req_ready=1, mem_valid=0, mem_addr=0, mem_wdata=0, mem_be=0, done=0, misalign_err=0.
- States: IDLE, BEAT0, BEAT1.
- Accept: a request is taken on req_valid & req_ready in IDLE, at cycle T. Addr, size and data are registered; req_* is ignored afterwards.
- Lane math: o = addr[1:0], n = 1/2/4 bytes.
  - Little-endian: byte k of req_data goes to lane (o+k) mod 4 for k < n.
  - be bits for lanes o..min(o+n,4)-1.
- Error (no macro): any size 11, half with o odd, or word with o != 0.
  - State stays IDLE; misalign_err=1 at T+1; mem_valid never asserts; done=0.
- Good request: state BEAT0 at T+1 with mem_valid=1, mem_addr = {addr[ADDR_W-1:2],2'b00}.
- Stability: mem_addr/mem_wdata/mem_be/mem_valid stay stable until mem_ready=1 (stall of any length).
- On the BEAT0 handshake:
  - If a second beat is needed, go to BEAT1 next cycle.
  - Otherwise go to IDLE with done=1 for that one cycle.
- Minimum latency: accept T, beat T+1, done/req_ready T+2.
- Back-to-back: a new request may be accepted in the same cycle done is high.
- mem_valid drops in IDLE; it is not required to be low between BEAT0 and BEAT1 (stays high).
- Reset mid-operation: outputs return to reset values immediately. The pending beat is abandoned, no done pulse, no error.
- done and misalign_err are never high in the same cycle.

Optional Feature:
- Macro: STORE_MISALIGN_SPLIT_EN.
- Defined:
  - Misaligned half/word are legal; only size 11 raises misalign_err.
  - Non-crossing (o+n <= 4) completes in one beat, e.g. half at o=1 gives be 0110.
  - Crossing (o+n > 4) uses two beats. BEAT0 covers lanes o..3 at the aligned address. BEAT1 uses aligned address + 4, wdata = req_data >> 8*(4-o) in low lanes, be = (1 << (o+n-4)) - 1. done follows the BEAT1 handshake.
  - The address wraps modulo 2^ADDR_W.
- Undefined: BEAT1 is unreachable; alignment errors as above.

Decomposition:
- Shared constants header store_defs: size codes SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD, and state encodings.
- One combinational sub-module, store_lane_pack: (offset, size, data, beat) -> (wdata, be, needs_second).
- The top holds the FSM and registers.

Test Plan:
- Byte store: addr 0x1002, size 00, data 0x123456AB, mem_ready=1 -> at T+1 mem_addr 0x1000, wdata 0x00AB0000, be 0100; done at T+2.
- Half store: addr 0x2002, data 0xCAFEBEEF -> wdata 0xBEEF0000, be 1100, single beat.
- Word store: addr 0x4000, data 0xDEADBEEF, mem_ready low for 3 cycles -> wdata 0xDEADBEEF, be 1111, outputs stable during the stall; done the cycle after mem_ready rises.
- Word at 0x3001, data 0x11223344:
  - Without macro -> misalign_err pulse at T+1, mem_valid never high.
  - With macro -> beat0 0x3000 / 0x22334400 / 1110, then beat1 0x3004 / 0x00000011 / 0001, then done.
- size 11 at any address -> misalign_err in both configs; reset asserted during a stalled BEAT0 -> mem_valid=0 immediately, no done, req_ready=1 after release.

Source files
------------

// File: rtl/store_lane_align_pkg.sv
// Shared definitions for the store lane aligner: size codes, FSM encoding and helpers.
// STORE_MISALIGN_SPLIT_EN relaxes alignment so misaligned half/word stores become legal.
package store_lane_align_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } state_e;

    // Lane mask of an unshifted store of the given size (lanes 0..n-1).
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_mask = 4'b0001;
            SZ_HALF: size_mask = 4'b0011;
            SZ_WORD: size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic size_illegal(input logic [1:0] size, input logic [1:0] off);
`ifdef STORE_MISALIGN_SPLIT_EN
        size_illegal = (size == SZ_RSVD) || (off > 2'd3);
`else
        size_illegal = (size == SZ_RSVD) ||
                       (size == SZ_HALF && off[0]) ||
                       (size == SZ_WORD && off != 2'd0);
`endif
    endfunction

endpackage

// File: rtl/store_lane_align_pack.sv
// Combinational lane packer: narrows the store value and rotates it onto memory lanes.
// Under STORE_MISALIGN_SPLIT_EN lanes spilling past lane 3 form a second beat.
module store_lane_align_pack
    import store_lane_align_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic [31:0] data,
    input  logic        beat,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        needs_second
);

    logic [3:0]  nmask;
    logic [31:0] dmask;
    logic [63:0] wide;
    logic [7:0]  wide_be;

    always_comb begin
        nmask   = size_mask(size);
        dmask   = data & {{8{nmask[3]}}, {8{nmask[2]}}, {8{nmask[1]}}, {8{nmask[0]}}};
        // Upper half of the 64-bit window is what spills into the next word.
        wide    = {32'b0, dmask} << {offset, 3'b000};
        wide_be = {4'b0, nmask} << offset;
        wdata   = beat ? wide[63:32] : wide[31:0];
        be      = beat ? wide_be[7:4] : wide_be[3:0];
`ifdef STORE_MISALIGN_SPLIT_EN
        needs_second = |wide_be[7:4];
`else
        needs_second = 1'b0;
`endif
    end

endmodule

// File: rtl/store_lane_align.sv
// Store lane aligner: accepts a store request, drives lane-aligned write beats to memory.
// Build option STORE_MISALIGN_SPLIT_EN enables two-beat word-crossing stores.
module store_lane_align
    import store_lane_align_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_data,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              done,
    output logic              misalign_err,
    output logic [1:0]        state_dbg
);

    // Handshakes: a transfer occurs on a rising edge where valid & ready are both high;
    // the initiator holds its payload stable while valid is high and ready is low.
    state_e      state;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic [31:0] data_q;
    logic        need2_q;
    logic        accept;

    logic [1:0]  pk_off;
    logic [1:0]  pk_size;
    logic [31:0] pk_data;
    logic        pk_beat;
    logic [31:0] pk_wdata;
    logic [3:0]  pk_be;
    logic        pk_second;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid & req_ready;
    assign state_dbg = state;

    // One packer: live request for beat 0 at accept, captured request for beat 1.
    always_comb begin
        pk_off  = off_q;
        pk_size = size_q;
        pk_data = data_q;
        pk_beat = 1'b1;
        if (state == ST_IDLE) begin
            pk_off  = req_addr[1:0];
            pk_size = req_size;
            pk_data = req_data;
            pk_beat = 1'b0;
        end
    end

    store_lane_align_pack u_pack (
        .offset       (pk_off),
        .size         (pk_size),
        .data         (pk_data),
        .beat         (pk_beat),
        .wdata        (pk_wdata),
        .be           (pk_be),
        .needs_second (pk_second)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            mem_valid    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            done         <= 1'b0;
            misalign_err <= 1'b0;
            off_q        <= '0;
            size_q       <= '0;
            data_q       <= '0;
            need2_q      <= 1'b0;
        end else begin
            done         <= 1'b0;
            misalign_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (size_illegal(req_size, req_addr[1:0])) begin
                            misalign_err <= 1'b1;
                        end else begin
                            state     <= ST_BEAT0;
                            mem_valid <= 1'b1;
                            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_wdata <= pk_wdata;
                            mem_be    <= pk_be;
                            need2_q   <= pk_second;
                            off_q     <= req_addr[1:0];
                            size_q    <= req_size;
                            data_q    <= req_data;
                        end
                    end
                end
                ST_BEAT0: begin
                    if (mem_ready) begin
                        if (need2_q) begin
                            state     <= ST_BEAT1;
                            mem_addr  <= mem_addr + ADDR_W'(4);
                            mem_wdata <= pk_wdata;
                            mem_be    <= pk_be;
                        end else begin
                            state     <= ST_IDLE;
                            mem_valid <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                ST_BEAT1: begin
                    if (mem_ready) begin
                        state     <= ST_IDLE;
                        mem_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_lane_align.sv
// Bench for store_lane_align: directed cases plus random stores against a byte-level model.
module tb_store_lane_align;

    localparam int EW = 70;
    localparam logic [1:0] K_BEAT = 2'd0;
    localparam logic [1:0] K_DONE = 2'd1;
    localparam logic [1:0] K_ERR  = 2'd2;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        done;
    logic        misalign_err;
    logic [1:0]  state_dbg;

    logic [EW-1:0] exp_q[$];
    int checks;
    int errors;
    logic rand_ready;

    store_lane_align #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_data     (req_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .done         (done),
        .misalign_err (misalign_err),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [EW-1:0] mk(input logic [1:0] k, input logic [31:0] a,
                                         input logic [31:0] w, input logic [3:0] b);
        mk = {k, a, w, b};
    endfunction

    task automatic check_eq(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Byte k of data lands in lane o+k of the 8-lane window spanning two words.
    task automatic model_push(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        int o, n, lane;
        logic err;
        logic [31:0] w0, w1, base;
        logic [3:0] b0, b1;
        o = int'(a[1:0]);
        n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : (s == 2'd2) ? 4 : 0;
`ifdef STORE_MISALIGN_SPLIT_EN
        err = (s == 2'd3);
`else
        err = (s == 2'd3) || (s == 2'd1 && (o % 2) != 0) || (s == 2'd2 && o != 0);
`endif
        if (err) begin
            exp_q.push_back(mk(K_ERR, 32'd0, 32'd0, 4'd0));
        end else begin
            w0 = '0; w1 = '0; b0 = '0; b1 = '0;
            base = a - 32'(o);
            for (int k = 0; k < n; k++) begin
                lane = o + k;
                if (lane < 4) begin
                    w0[8*lane +: 8] = d[8*k +: 8];
                    b0[lane] = 1'b1;
                end else begin
                    w1[8*(lane-4) +: 8] = d[8*k +: 8];
                    b1[lane-4] = 1'b1;
                end
            end
            exp_q.push_back(mk(K_BEAT, base, w0, b0));
            if (b1 != 4'd0) exp_q.push_back(mk(K_BEAT, base + 32'd4, w1, b1));
            exp_q.push_back(mk(K_DONE, 32'd0, 32'd0, 4'd0));
        end
    endtask

    // ---------------- drivers ----------------
    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance (T+1).
    task automatic issue(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        int g;
        g = 0;
        while (!req_ready && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
        end
        req_valid = 1'b1;
        req_addr  = a;
        req_size  = s;
        req_data  = d;
        model_push(a, s, d);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_size  = 2'($urandom_range(0, 3));
        req_data  = $urandom;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk); #2;
            if (rand_ready) mem_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic        stall_prev;
    logic [31:0] prev_addr, prev_wdata;
    logic [3:0]  prev_be;

    task automatic pop_cmp(input string name, input logic [EW-1:0] got);
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s_unexpected: got %h expected none", name, got);
        end else begin
            check_eq(name, got, exp_q.pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (done && misalign_err) begin
                checks++; errors++;
                $display("FAIL done_err_overlap: got 1 expected 0");
            end
            if (stall_prev)
                check_eq("stall_stable", mk(K_BEAT, mem_addr, mem_wdata, {mem_be[3:1], mem_be[0] & mem_valid}),
                         mk(K_BEAT, prev_addr, prev_wdata, {prev_be[3:1], prev_be[0]}));
            if (stall_prev && !mem_valid) begin
                checks++; errors++;
                $display("FAIL stall_valid_drop: got 0 expected 1");
            end
            if (mem_valid && mem_ready) pop_cmp("beat", mk(K_BEAT, mem_addr, mem_wdata, mem_be));
            if (done) pop_cmp("done", mk(K_DONE, 32'd0, 32'd0, 4'd0));
            if (misalign_err) pop_cmp("err", mk(K_ERR, 32'd0, 32'd0, 4'd0));
            stall_prev = mem_valid && !mem_ready;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
            prev_be    = mem_be;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int g;
        logic [31:0] a;
        checks = 0; errors = 0;
        rand_ready = 1'b0;
        mem_ready = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_size = '0; req_data = '0;
        rst_n = 1'b0;
        cycles(3);
        check_eq("reset_outputs", {mem_valid, req_ready, done, misalign_err, mem_addr, mem_wdata, mem_be, 2'b00},
                 {1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 2'b00});
        rst_n = 1'b1;
        cycles(2);

        // byte store: exact latency
        issue(32'h0000_1002, 2'b00, 32'h1234_56AB);
        check_eq("byte_t1", {mem_valid, mem_addr, mem_wdata, mem_be}, {1'b1, 32'h1000, 32'h00AB_0000, 4'b0100});
        cycles(1);
        check_eq("byte_t2_done", {done, req_ready}, {1'b1, 1'b1});

        // half store
        cycles(1);
        issue(32'h0000_2002, 2'b01, 32'hCAFE_BEEF);
        check_eq("half_t1", {mem_valid, mem_wdata, mem_be}, {1'b1, 32'hBEEF_0000, 4'b1100});
        cycles(1);
        check_eq("half_t2_done", done, 1'b1);

        // word store with 3-cycle stall
        mem_ready = 1'b0;
        issue(32'h0000_4000, 2'b10, 32'hDEAD_BEEF);
        cycles(3);
        check_eq("word_stall", {mem_valid, done, mem_wdata, mem_be}, {1'b1, 1'b0, 32'hDEAD_BEEF, 4'b1111});
        mem_ready = 1'b1;
        cycles(1);
        check_eq("word_done", done, 1'b1);

        // misaligned word
        issue(32'h0000_3001, 2'b10, 32'h1122_3344);
`ifdef STORE_MISALIGN_SPLIT_EN
        check_eq("mis_word_b0", {mem_valid, mem_addr, mem_wdata, mem_be}, {1'b1, 32'h3000, 32'h2233_4400, 4'b1110});
        cycles(1);
        check_eq("mis_word_b1", {mem_valid, mem_addr, mem_wdata, mem_be}, {1'b1, 32'h3004, 32'h0000_0011, 4'b0001});
        cycles(1);
        check_eq("mis_word_done", done, 1'b1);
`else
        check_eq("mis_word_err", {misalign_err, mem_valid, done}, {1'b1, 1'b0, 1'b0});
        cycles(1);
        check_eq("mis_word_quiet", {misalign_err, mem_valid, done}, {1'b0, 1'b0, 1'b0});
`endif

        // reserved size
        cycles(1);
        issue(32'h0000_5003, 2'b11, 32'hFFFF_FFFF);
        check_eq("rsvd_err", {misalign_err, mem_valid}, {1'b1, 1'b0});

        // reset during a stalled beat
        cycles(1);
        mem_ready = 1'b0;
        issue(32'h0000_6000, 2'b10, 32'h0BAD_F00D);
        cycles(1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_op", {mem_valid, done, misalign_err, req_ready}, {1'b0, 1'b0, 1'b0, 1'b1});
        exp_q.delete();
        cycles(2);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        cycles(4);
        check_eq("rst_after", {req_ready, mem_valid, done}, {1'b1, 1'b0, 1'b0});

        // random stores, random memory backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            issue(a, 2'($urandom_range(0, 3)), $urandom);
            if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 3));
        end

        g = 0;
        while (exp_q.size() != 0 && g < 2000) begin
            cycles(1);
            g++;
        end
        check_eq("drain_empty", EW'(exp_q.size()), EW'(0));
        cycles(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
